// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: credit-limited pipelined fetch into a small in-order buffer.
// Build option IF_BYPASS_EN lets a response reach the outputs in its arrival cycle when the buffer is empty.
module if_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] PC_IF,
   output logic [31:0] instr_IF,
   output logic        valid_IF
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [31:0]   NOP     = 32'h0000_0013;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [31:0]   fetch_pc;
   logic [CW-1:0] inflight;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] fifo_count;
   logic [AW-1:0] fifo_rd;
   logic [AW-1:0] fifo_wr;
   logic [AW-1:0] pcq_rd;
   logic [AW-1:0] pcq_wr;
   logic [31:0]   fifo_pc    [FIFO_DEPTH];
   logic [31:0]   fifo_instr [FIFO_DEPTH];
   logic [31:0]   pcq        [FIFO_DEPTH];

   logic [CW:0]   credits_used;
   logic [CW-1:0] inflight_next;
   logic          issue;
   logic          fifo_empty;
   logic          rsp_keep;
   logic          bypass;
   logic          push;
   logic          pop;
   logic [31:0]   rsp_pc;

   // Every outstanding request owns a buffer slot, so a returning word can always be pushed.
   assign credits_used  = {1'b0, inflight} + {1'b0, fifo_count};
   assign imem_req      = !rst && !redirect && (credits_used < {1'b0, DEPTH_C});
   assign imem_addr     = fetch_pc;
   assign issue         = imem_req && imem_gnt;
   assign inflight_next = inflight + CW'(issue) - CW'(imem_rvalid);

   assign fifo_empty = (fifo_count == '0);
   assign rsp_keep   = imem_rvalid && (drop_cnt == '0) && !redirect;
   assign rsp_pc     = pcq[pcq_rd];

`ifdef IF_BYPASS_EN
   assign bypass = rsp_keep && fifo_empty;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed word that is taken downstream never occupies the buffer.
   assign push = rsp_keep && !(bypass && !stall);
   assign pop  = !fifo_empty && !stall && !redirect;

   always_comb begin
      PC_IF    = RESET_PC;
      instr_IF = NOP;
      valid_IF = 1'b0;
      if (!fifo_empty) begin
         PC_IF    = fifo_pc[fifo_rd];
         instr_IF = fifo_instr[fifo_rd];
         valid_IF = 1'b1;
      end else if (bypass) begin
         PC_IF    = rsp_pc;
         instr_IF = imem_rdata;
         valid_IF = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
      end else if (redirect) begin
         fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      end else if (issue) begin
         fetch_pc <= fetch_pc + 32'd4;
      end
   end

   // On redirect every response still owed by memory is stale; the one arriving now is dropped too.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= '0;
         drop_cnt <= '0;
      end else begin
         inflight <= inflight_next;
         if (redirect) begin
            drop_cnt <= inflight - CW'(imem_rvalid);
         end else if (imem_rvalid && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcq_rd <= '0;
         pcq_wr <= '0;
      end else begin
         if (issue) begin
            pcq_wr <= pcq_wr + AW'(1);
         end
         if (imem_rvalid) begin
            pcq_rd <= pcq_rd + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (issue) begin
         pcq[pcq_wr] <= fetch_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || redirect) begin
         fifo_rd    <= '0;
         fifo_wr    <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            fifo_wr <= fifo_wr + AW'(1);
         end
         if (pop) begin
            fifo_rd <= fifo_rd + AW'(1);
         end
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[fifo_wr]    <= rsp_pc;
         fifo_instr[fifo_wr] <= imem_rdata;
      end
   end

   a_inflight_bound: assert property (@(posedge clk) disable iff (rst) inflight <= DEPTH_C);
   a_drop_bound:     assert property (@(posedge clk) disable iff (rst) drop_cnt <= inflight);
   a_rsp_expected:   assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> (inflight != '0));
   a_no_overflow:    assert property (@(posedge clk) disable iff (rst)
                                      !(push && !pop && (fifo_count == DEPTH_C)));

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: in-order memory model plus a transaction-level fetch reference.
// Honours IF_BYPASS_EN the same way the design does.
`timescale 1ns/1ps
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0100;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef IF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] PC_IF;
   logic [31:0] instr_IF;
   logic        valid_IF;

   always #5 clk = ~clk;

   if_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .PC_IF(PC_IF), .instr_IF(instr_IF), .valid_IF(valid_IF)
   );

   int ncmp = 0;
   int nerr = 0;
   int cyc  = 0;
   int lat  = 1;
   int gnt_mode = 0;

   // Memory: outstanding addresses with their due cycle. Reference: delivered-but-unconsumed PCs.
   logic [31:0] mq_addr[$];
   int          mq_due[$];
   logic [31:0] buf_pc[$];
   int          stale = 0;
   logic [31:0] m_pc = RESET_PC;
   logic [31:0] next_pc = RESET_PC;

   logic        exp_req;
   logic [31:0] exp_addr;
   logic        exp_valid;
   logic [31:0] exp_pc;
   logic [31:0] exp_instr;
   logic        first_into_empty;
   logic        issued;
   logic [31:0] last_issue;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'h5A5A_1234;
   endfunction

   // One clock: drive inputs after the edge, derive expectations, advance the reference at the edge.
   task automatic drive_cycle(input logic rs, input logic s, input logic r, input logic [31:0] rpc);
      logic        accept;
      logic        byp;
      logic [31:0] a;
      @(posedge clk);
      #1;
      rst = rs;
      stall = s;
      redirect = r;
      redirect_pc = rpc;
      case (gnt_mode)
         0:       imem_gnt = 1'b1;
         1:       imem_gnt = 1'($urandom_range(0, 1));
         default: imem_gnt = (cyc % 2 == 0);
      endcase
      if (!rs && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = word_of(mq_addr[0]);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      #3;
      accept           = imem_rvalid && stale == 0 && !r;
      first_into_empty = accept && buf_pc.size() == 0;
      byp              = BYP && first_into_empty;
      exp_req   = !rs && !r && (mq_addr.size() + buf_pc.size() < DEPTH);
      exp_addr  = m_pc;
      exp_valid = buf_pc.size() > 0 || byp;
      exp_pc    = buf_pc.size() > 0 ? buf_pc[0] : (byp ? mq_addr[0] : RESET_PC);
      exp_instr = exp_valid ? word_of(exp_pc) : NOP;
      issued     = imem_req && imem_gnt;
      last_issue = imem_addr;
      if (rs) begin
         mq_addr.delete();
         mq_due.delete();
         buf_pc.delete();
         stale = 0;
         m_pc  = RESET_PC;
      end else if (r) begin
         if (imem_rvalid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
         end
         buf_pc.delete();
         stale = mq_addr.size();
         m_pc  = rpc & 32'hFFFF_FFFC;
      end else begin
         if (buf_pc.size() > 0 && !s) void'(buf_pc.pop_front());
         if (imem_rvalid) begin
            a = mq_addr.pop_front();
            void'(mq_due.pop_front());
            if (stale > 0) stale--;
            else if (!(byp && !s)) buf_pc.push_back(a);
         end
         if (issued) begin
            mq_addr.push_back(imem_addr);
            mq_due.push_back(cyc + lat);
            m_pc = m_pc + 32'd4;
         end
      end
      cyc++;
   endtask

   task automatic test_reset();
      gnt_mode = 0;
      lat = 1;
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      ncmp++; if (imem_req !== 1'b0) begin nerr++; $display("[TB] FAIL reset_req got=%0b want=0", imem_req); end
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      ncmp++; if (valid_IF !== 1'b0) begin nerr++; $display("[TB] FAIL reset_valid got=%0b want=0", valid_IF); end
      ncmp++; if (PC_IF !== RESET_PC) begin nerr++; $display("[TB] FAIL reset_pc got=%h want=%h", PC_IF, RESET_PC); end
      ncmp++; if (instr_IF !== NOP) begin nerr++; $display("[TB] FAIL reset_instr got=%h want=%h", instr_IF, NOP); end
      ncmp++; if (imem_req !== 1'b1) begin nerr++; $display("[TB] FAIL reset_first_req got=%0b want=1", imem_req); end
      ncmp++; if (imem_addr !== RESET_PC) begin nerr++; $display("[TB] FAIL reset_first_addr got=%h want=%h", imem_addr, RESET_PC); end
      next_pc = RESET_PC;
   endtask

   task automatic test_stream();
      for (int i = 0; i < 14; i++) begin
         drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
         ncmp++; if (imem_req !== exp_req) begin nerr++; $display("[TB] FAIL stream_req cyc=%0d got=%0b want=%0b", cyc, imem_req, exp_req); end
         if (exp_req) begin
            ncmp++; if (imem_addr !== exp_addr) begin nerr++; $display("[TB] FAIL stream_addr got=%h want=%h", imem_addr, exp_addr); end
         end
         ncmp++; if (valid_IF !== exp_valid) begin nerr++; $display("[TB] FAIL stream_valid cyc=%0d got=%0b want=%0b", cyc, valid_IF, exp_valid); end
         if (exp_valid) begin
            ncmp++; if (PC_IF !== next_pc) begin nerr++; $display("[TB] FAIL stream_order got=%h want=%h", PC_IF, next_pc); end
            ncmp++; if (instr_IF !== exp_instr) begin nerr++; $display("[TB] FAIL stream_instr got=%h want=%h", instr_IF, exp_instr); end
            next_pc = next_pc + 32'd4;
         end
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
         ncmp++; if (imem_req !== exp_req) begin nerr++; $display("[TB] FAIL stall_req cyc=%0d got=%0b want=%0b", cyc, imem_req, exp_req); end
         ncmp++; if (valid_IF !== exp_valid) begin nerr++; $display("[TB] FAIL stall_valid got=%0b want=%0b", valid_IF, exp_valid); end
         if (exp_valid) begin
            ncmp++; if (PC_IF !== next_pc) begin nerr++; $display("[TB] FAIL stall_hold_pc got=%h want=%h", PC_IF, next_pc); end
         end
      end
      ncmp++; if (imem_req !== 1'b0) begin nerr++; $display("[TB] FAIL stall_credits got=%0b want=0", imem_req); end
      ncmp++; if (valid_IF !== 1'b1) begin nerr++; $display("[TB] FAIL stall_valid_end got=%0b want=1", valid_IF); end
      for (int i = 0; i < 10; i++) begin
         drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
         ncmp++; if (valid_IF !== exp_valid) begin nerr++; $display("[TB] FAIL release_valid got=%0b want=%0b", valid_IF, exp_valid); end
         if (exp_valid) begin
            ncmp++; if (PC_IF !== next_pc) begin nerr++; $display("[TB] FAIL release_order got=%h want=%h", PC_IF, next_pc); end
            ncmp++; if (instr_IF !== exp_instr) begin nerr++; $display("[TB] FAIL release_instr got=%h want=%h", instr_IF, exp_instr); end
            next_pc = next_pc + 32'd4;
         end
      end
   endtask

   task automatic test_redirect();
      bit seen_req = 0;
      bit seen_valid = 0;
      lat = 3;
      for (int i = 0; i < 12 && mq_addr.size() < 2; i++) begin
         drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
         if (valid_IF) next_pc = PC_IF + 32'd4;
      end
      ncmp++; if (mq_addr.size() != 2) begin nerr++; $display("[TB] FAIL redir_setup inflight=%0d want=2", mq_addr.size()); end
      drive_cycle(1'b0, 1'b0, 1'b1, 32'h0000_2002);
      ncmp++; if (imem_req !== 1'b0) begin nerr++; $display("[TB] FAIL redir_req got=%0b want=0", imem_req); end
      for (int i = 0; i < 30 && !seen_valid; i++) begin
         drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
         ncmp++; if (imem_req !== exp_req) begin nerr++; $display("[TB] FAIL redir_req_model cyc=%0d got=%0b want=%0b", cyc, imem_req, exp_req); end
         if (imem_req && !seen_req) begin
            seen_req = 1;
            ncmp++; if (imem_addr !== 32'h0000_2000) begin nerr++; $display("[TB] FAIL redir_addr got=%h want=00002000", imem_addr); end
         end
         ncmp++; if (valid_IF !== exp_valid) begin nerr++; $display("[TB] FAIL redir_valid got=%0b want=%0b", valid_IF, exp_valid); end
         if (valid_IF) begin
            seen_valid = 1;
            ncmp++; if (PC_IF !== 32'h0000_2000) begin nerr++; $display("[TB] FAIL redir_first_pc got=%h want=00002000", PC_IF); end
            next_pc = 32'h0000_2004;
         end
      end
      ncmp++; if (!seen_valid) begin nerr++; $display("[TB] FAIL redir_timeout got=no_valid want=valid"); end
   endtask

   task automatic test_redirect_full();
      logic [31:0] tgt;
      bit seen_valid = 0;
      lat = 1;
      for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      ncmp++; if (valid_IF !== 1'b1) begin nerr++; $display("[TB] FAIL full_valid got=%0b want=1", valid_IF); end
      tgt = {4'h4, 28'($urandom) & 28'hFFF_FFFC};
      drive_cycle(1'b0, 1'b1, 1'b1, tgt | 32'h1);
      drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      ncmp++; if (valid_IF !== 1'b0) begin nerr++; $display("[TB] FAIL full_flush got=%0b want=0", valid_IF); end
      if (imem_req) begin
         ncmp++; if (imem_addr !== tgt) begin nerr++; $display("[TB] FAIL full_restart got=%h want=%h", imem_addr, tgt); end
      end
      for (int i = 0; i < 20 && !seen_valid; i++) begin
         drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
         if (valid_IF) begin
            seen_valid = 1;
            ncmp++; if (PC_IF !== tgt) begin nerr++; $display("[TB] FAIL full_first_pc got=%h want=%h", PC_IF, tgt); end
            next_pc = tgt + 32'd4;
         end
      end
      ncmp++; if (!seen_valid) begin nerr++; $display("[TB] FAIL full_timeout got=no_valid want=valid"); end
   endtask

   task automatic test_gnt_toggle();
      logic s;
      gnt_mode = 2;
      lat = 3;
      for (int i = 0; i < 60; i++) begin
         s = ($urandom_range(0, 3) == 0);
         drive_cycle(1'b0, s, 1'b0, 32'h0);
         ncmp++; if (mq_addr.size() > DEPTH) begin nerr++; $display("[TB] FAIL toggle_inflight got=%0d want<=%0d", mq_addr.size(), DEPTH); end
         ncmp++; if (imem_req !== exp_req) begin nerr++; $display("[TB] FAIL toggle_req cyc=%0d got=%0b want=%0b", cyc, imem_req, exp_req); end
         ncmp++; if (valid_IF !== exp_valid) begin nerr++; $display("[TB] FAIL toggle_valid got=%0b want=%0b", valid_IF, exp_valid); end
         if (exp_valid && !s) begin
            ncmp++; if (PC_IF !== next_pc) begin nerr++; $display("[TB] FAIL toggle_order got=%h want=%h", PC_IF, next_pc); end
            next_pc = next_pc + 32'd4;
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] want [3];
      int n = 0;
      want[0] = 32'hFFFF_FFF8;
      want[1] = 32'hFFFF_FFFC;
      want[2] = 32'h0000_0000;
      gnt_mode = 0;
      lat = 1;
      drive_cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFB);
      next_pc = 32'hFFFF_FFF8;
      for (int i = 0; i < 16; i++) begin
         drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
         if (issued && n < 3) begin
            ncmp++; if (last_issue !== want[n]) begin nerr++; $display("[TB] FAIL wrap_addr%0d got=%h want=%h", n, last_issue, want[n]); end
            n++;
         end
         if (first_into_empty) begin
            ncmp++; if (valid_IF !== BYP) begin nerr++; $display("[TB] FAIL bypass_latency got=%0b want=%0b", valid_IF, BYP); end
         end
         if (valid_IF) begin
            ncmp++; if (PC_IF !== next_pc) begin nerr++; $display("[TB] FAIL wrap_order got=%h want=%h", PC_IF, next_pc); end
            next_pc = next_pc + 32'd4;
         end
      end
      ncmp++; if (n != 3) begin nerr++; $display("[TB] FAIL wrap_issue_count got=%0d want=3", n); end
   endtask

   task automatic test_random();
      logic s;
      logic r;
      logic [31:0] rpc;
      gnt_mode = 1;
      for (int i = 0; i < 250; i++) begin
         lat = $urandom_range(1, 3);
         s   = ($urandom_range(0, 9) < 3);
         r   = ($urandom_range(0, 19) == 0);
         rpc = $urandom;
         drive_cycle(1'b0, s, r, rpc);
         ncmp++; if (imem_req !== exp_req) begin nerr++; $display("[TB] FAIL rand_req cyc=%0d got=%0b want=%0b", cyc, imem_req, exp_req); end
         if (exp_req) begin
            ncmp++; if (imem_addr !== exp_addr) begin nerr++; $display("[TB] FAIL rand_addr got=%h want=%h", imem_addr, exp_addr); end
         end
         ncmp++; if (valid_IF !== exp_valid) begin nerr++; $display("[TB] FAIL rand_valid cyc=%0d got=%0b want=%0b", cyc, valid_IF, exp_valid); end
         if (exp_valid) begin
            ncmp++; if (PC_IF !== exp_pc) begin nerr++; $display("[TB] FAIL rand_pc got=%h want=%h", PC_IF, exp_pc); end
            ncmp++; if (instr_IF !== exp_instr) begin nerr++; $display("[TB] FAIL rand_instr got=%h want=%h", instr_IF, exp_instr); end
         end
         if (r) begin
            next_pc = rpc & 32'hFFFF_FFFC;
         end else if (exp_valid && !s) begin
            ncmp++; if (PC_IF !== next_pc) begin nerr++; $display("[TB] FAIL rand_order got=%h want=%h", PC_IF, next_pc); end
            next_pc = next_pc + 32'd4;
         end
         ncmp++; if (mq_addr.size() > DEPTH) begin nerr++; $display("[TB] FAIL rand_inflight got=%0d want<=%0d", mq_addr.size(), DEPTH); end
      end
   endtask

   initial begin
      $display("[TB] if_stage bench start, bypass=%0b", BYP);
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_full();
      test_gnt_toggle();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
